// File: rtl/jzjpcc_decode_pkg.sv
// Shared decode types: the decoded instruction bundle carried from
// decode to execute, field widths, and the writeback snoop helper.
package jzjpcc_decode_pkg;

    localparam int PC_MAX_B   = 31;
    localparam int DATA_W     = 32;
    localparam int ALU_OP_W   = 3;
    localparam int ALU_MUX_W  = 2;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [ALU_OP_W-1:0]   aluOperation;
        logic                  aluMod;
        logic [ALU_MUX_W-1:0]  aluMuxMode;
        logic                  memoryWriteEnable;
        logic [1:0]            rdSource;
        logic                  rdWriteEnable;
        logic [REG_ADDR_W-1:0] rdAddr;
        logic [2:0]            funct3;
        logic [DATA_W-1:0]     immediate;
        logic [PC_MAX_B:2]     currentPC;
        logic [DATA_W-1:0]     rs1;
        logic [DATA_W-1:0]     rs2;
        logic [REG_ADDR_W-1:0] rs1Addr;
        logic [REG_ADDR_W-1:0] rs2Addr;
    } decoded_bundle_t;

    // Replace stale operands with the value being written back.
    // x0 is hardwired to zero and is never forwarded.
    function automatic decoded_bundle_t snoop(
        decoded_bundle_t        b,
        logic                   v,
        logic [REG_ADDR_W-1:0]  a,
        logic [DATA_W-1:0]      d
    );
        decoded_bundle_t r;
        r = b;
        if (v && (a != '0)) begin
            if (b.rs1Addr == a) r.rs1 = d;
            if (b.rs2Addr == a) r.rs2 = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/jzjpcc_issue_queue_entry.sv
// One issue-queue storage slot: loads a snooped bundle on write and
// otherwise keeps its rs1/rs2 operands current from the writeback port.
// Ports: clock, write, wbValid/wbAddr/wbValue (snoop), wdata in, q out.
module jzjpcc_issue_queue_entry
    import jzjpcc_decode_pkg::*;
(
    input  logic                  clock,
    input  logic                  write,
    input  logic                  wbValid,
    input  logic [REG_ADDR_W-1:0] wbAddr,
    input  logic [DATA_W-1:0]     wbValue,
    input  decoded_bundle_t       wdata,
    output decoded_bundle_t       q
);

    // Storage is intentionally not reset; occupancy lives in the queue.
    // Snooping a free slot is harmless since enqueue overwrites it.
    always_ff @(posedge clock) begin
        if (write) q <= snoop(wdata, wbValid, wbAddr, wbValue);
        else       q <= snoop(q, wbValid, wbAddr, wbValue);
    end

endmodule

// File: rtl/jzjpcc_issue_queue.sv
// Circular decode-to-execute issue queue with valid/ready on both sides,
// writeback operand snooping and whole-queue flush.
// Ports: clock, reset (async low), in*/out* handshakes, flush, wb*, count.
module jzjpcc_issue_queue
    import jzjpcc_decode_pkg::*;
#(
    parameter int PC_MAX_B = 31,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         inValid,
    output logic                         inReady,
    input  decoded_bundle_t              inBundle,
    output logic                         outValid,
    input  logic                         outReady,
    output decoded_bundle_t              outBundle,
    input  logic                         flush,
    input  logic                         wbValid,
    input  logic [REG_ADDR_W-1:0]        wbAddr,
    input  logic [DATA_W-1:0]            wbValue,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // The bundle layout is fixed by the package; catch mismatched overrides.
    if (PC_MAX_B != jzjpcc_decode_pkg::PC_MAX_B ||
        DATA_W != jzjpcc_decode_pkg::DATA_W) begin : g_bad_width
        $error("jzjpcc_issue_queue: widths differ from jzjpcc_decode_pkg");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("jzjpcc_issue_queue: DEPTH must be a power of two >= 2");
    end

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             enq;
    logic             deq;
    decoded_bundle_t  slots [DEPTH];

    // Full refuses input even when the head leaves this cycle.
    assign inReady  = (count != CNT_W'(DEPTH));
    assign outValid = (count != '0);
    assign enq      = inValid && inReady && !flush;
    assign deq      = outValid && outReady && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        jzjpcc_issue_queue_entry u_entry (
            .clock   (clock),
            .write   (enq && (tail == PTR_W'(i))),
            .wbValid (wbValid),
            .wbAddr  (wbAddr),
            .wbValue (wbValue),
            .wdata   (inBundle),
            .q       (slots[i])
        );
    end

    // Same-cycle writeback is visible to a dequeue at the head.
    assign outBundle = snoop(slots[head], wbValid, wbAddr, wbValue);

endmodule

// File: doc/jzjpcc_issue_queue.md
Name: jzjpcc_issue_queue

Overview:
Parametrised decode-to-execute buffer; the next generation of the single-register decode/execute latch. It holds up to DEPTH decoded instruction bundles in a circular FIFO and issues them to execute under a valid/ready handshake, so decode and execute can stall independently. Buffered operands are kept current by snooping a writeback port, which replaces per-stage bypass muxing. Flush clears the whole queue.

Parameters:
PC_MAX_B, 31, MSB of the word-aligned PC field (PC stored as [PC_MAX_B:2]).
DATA_W, 32, register/operand/immediate width.
DEPTH, 4, number of entries; power of two, >= 2.

Ports:
clock  input  1  sole clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
inValid  input  1  decode presents a bundle.
inReady  output  1  queue can accept; equals (count != DEPTH); no combinational dependence on outReady.
inBundle  input  $bits(decoded_bundle_t)  aluOperation, aluMod, aluMuxMode, memoryWriteEnable, rdSource, rdWriteEnable, rdAddr, funct3, immediate, currentPC, rs1, rs2, rs1Addr, rs2Addr.
outValid  output  1  head entry is valid; equals (count != 0).
outReady  input  1  execute accepts head this cycle.
outBundle  output  $bits(decoded_bundle_t)  head entry with snoop forwarding applied (see Behaviour).
flush  input  1  synchronous discard of all entries.
wbValid  input  1  writeback snoop strobe.
wbAddr  input  5  writeback destination register.
wbValue  input  DATA_W  writeback data.
count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset==0, async): head=tail=0, count=0. Therefore outValid=0 and inReady=1. Entry storage is not reset.
- Enqueue when inValid&&inReady: entry[tail]<=inBundle (after snoop), tail<=tail+1 mod DEPTH.
- Dequeue when outValid&&outReady: head<=head+1 mod DEPTH.
- Count: +1 on enqueue only, -1 on dequeue only, unchanged on both.
- Full: no pass-through. inReady stays 0 even if a dequeue happens the same cycle; it rises the following cycle.
- Latency: minimum 1 cycle. A bundle enqueued at edge N drives outValid after edge N. There is no combinational path from in to out.
- Flush has highest priority. On the next edge head=tail=count=0. A same-cycle enqueue is dropped and a same-cycle dequeue is ignored. outValid is still driven combinationally from count during the flush cycle, so execute discards it using its own flush.
- Snoop:
  - Active when wbValid && wbAddr!=0.
  - Every occupied entry with rs1Addr==wbAddr gets rs1<=wbValue; likewise rs2/rs2Addr.
  - The same match is applied to inBundle before it is written on enqueue.
  - outBundle.rs1/rs2 are combinationally overridden by wbValue on a match, so a dequeue in the same cycle sees the fresh value.
  - x0 is never matched.
  - The pipeline guarantees that wb comes from an instruction older than every buffered entry.
- Pointer wrap: head/tail are $clog2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- Reset mid-operation: all entries lost immediately; outValid falls asynchronously.

Decomposition:
- Package jzjpcc_decode_pkg holds:
  - decoded_bundle_t, a packed struct, parametrised via localparams matching PC_MAX_B/DATA_W defaults, or a parametrised-class-free typedef per instantiation.
  - Width constants for control fields: ALU_OP_W=3 and ALU_MUX_W=2.
  - REG_ADDR_W=5.
- Sub-module jzjpcc_issue_queue_entry is one storage slot with write-enable and the rs1/rs2 snoop compare-and-update. It is instantiated DEPTH times in a generate loop.

Test Plan:
1. Reset, then enqueue 4 bundles (PC 0x10, 0x14, 0x18, 0x1C) with outReady=0 -> count=4, inReady=0. Raising outReady then yields the PCs in order, one per cycle, and count returns to 0.
2. Full queue with inValid=1 and outReady=1 in the same cycle -> dequeue occurs, enqueue refused (inReady=0), count 4->3. The next cycle inReady=1.
3. Entry with rs1Addr=5, rs1=0xDEAD buffered; pulse wbValid, wbAddr=5, wbValue=0x1234 -> on dequeue outBundle.rs1=0x1234 and rs2 is unchanged. Repeat with wbAddr=0 and rs1Addr=0 -> no update.
4. Enqueue an entry with rs2Addr=7 in the same cycle as wbAddr=7, wbValue=0xCAFE -> the stored rs2=0xCAFE. A head dequeued during a matching wb shows wbValue combinationally.
5. Queue holding 3 entries; assert flush together with inValid=1 and outReady=1 -> the next cycle count=0, outValid=0, and the new bundle is absent.
6. Drive reset=0 asynchronously mid-cycle with count=2 -> outValid=0 and count=0 before the next edge. After release, 6 enqueue/dequeue cycles wrap the pointers past DEPTH with ordering preserved.
